mac_pe_v2: RTL and testbench

MAC_PE_V2 -- requirements
Module: mac_pe_v2

---
 rtl/mac_pe_v2_pkg.sv | 17 +
 rtl/pe_sat_resize.sv | 30 +++
 rtl/mac_pe_v2.sv | 153 +++++++++++++++
 tb/tb_mac_pe_v2.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pe_v2_pkg.sv
// Shared types and default widths for the mac_pe_v2 processing element.
package pe_pkg;

    typedef enum logic {
        PE_WS = 1'b0,
        PE_OS = 1'b1
    } pe_mode_e;

    localparam int PE_DATA_W = 8;
    localparam int PE_ACC_W  = 16;
    localparam int PE_WBANKS = 2;

    function automatic int pe_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_sat_resize.sv
// Signed resize from IN_W to OUT_W bits: sign-extend, saturate or truncate.
module pe_sat_resize #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 16,
    parameter int SAT_EN = 1
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_o,
    output logic             sat_o
);

    if (IN_W <= OUT_W) begin : g_ext
        assign out_o = OUT_W'($signed(in_i));
        assign sat_o = 1'b0;
    end else if (SAT_EN != 0) begin : g_sat
        logic ovf;
        // Value fits only if all dropped bits equal the new sign bit.
        assign ovf   = ~(&in_i[IN_W-1:OUT_W-1]) & (|in_i[IN_W-1:OUT_W-1]);
        assign out_o = !ovf ? in_i[OUT_W-1:0] :
                       in_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                      {1'b0, {(OUT_W-1){1'b1}}};
        assign sat_o = ovf;
    end else begin : g_wrap
        logic [IN_W-OUT_W-1:0] drop;
        assign drop  = in_i[IN_W-1:OUT_W];
        assign out_o = in_i[OUT_W-1:0];
        assign sat_o = 1'b0;
    end

endmodule

// File: rtl/mac_pe_v2.sv
// Systolic MAC processing element, weight- or output-stationary.
module mac_pe_v2
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int ACC_W  = PE_ACC_W,
    parameter int WBANKS = PE_WBANKS,
    parameter int SAT_EN = 1,
    localparam int SEL_W = pe_sel_w(WBANKS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ctrl_mode_i,
    input  logic              ctrl_load_i,
    input  logic [SEL_W-1:0]  ctrl_load_sel_i,
    input  logic [SEL_W-1:0]  ctrl_wsel_i,
    input  logic              ctrl_ps_in_i,
    input  logic              ctrl_drain_i,
    input  logic              ctrl_clear_i,
    input  logic [DATA_W-1:0] west_i,
    input  logic              west_valid_i,
    input  logic [ACC_W-1:0]  north_i,
    input  logic              north_valid_i,
    output logic [DATA_W-1:0] east_o,
    output logic              east_valid_o,
    output logic [ACC_W-1:0]  south_o,
    output logic              south_valid_o,
    output logic              sat_flag_o
);

    pe_mode_e mode;
    logic [DATA_W-1:0] w_q [WBANKS];
    logic [DATA_W-1:0] w_rd;
    logic [DATA_W-1:0] op_b;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0] prod_r;
    logic [ACC_W-1:0] addend;
    logic [ACC_W:0] sum;
    logic [ACC_W-1:0] sum_r;
    logic prod_sat, sum_sat;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] south_q, south_d;
    logic south_v_q, south_v_d;
    logic sat_q, sat_d;
    logic [DATA_W-1:0] east_q;
    logic east_v_q;

    assign mode = pe_mode_e'(ctrl_mode_i);

    // Unmatched (out-of-range) selects leave the read at zero.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < WBANKS; i++) begin
            if (ctrl_wsel_i == SEL_W'(i)) w_rd = w_q[i];
        end
    end

    assign op_b = (mode == PE_WS) ? w_rd : north_i[DATA_W-1:0];
    assign prod = $signed(west_i) * $signed(op_b);

    pe_sat_resize #(
        .IN_W  (2*DATA_W),
        .OUT_W (ACC_W),
        .SAT_EN(SAT_EN)
    ) u_prod_rs (
        .in_i (prod),
        .out_o(prod_r),
        .sat_o(prod_sat)
    );

    always_comb begin
        addend = acc_q;
        if (mode == PE_WS) addend = ctrl_ps_in_i ? north_i : '0;
    end

    assign sum = {addend[ACC_W-1], addend} + {prod_r[ACC_W-1], prod_r};

    pe_sat_resize #(
        .IN_W  (ACC_W+1),
        .OUT_W (ACC_W),
        .SAT_EN(SAT_EN)
    ) u_sum_rs (
        .in_i (sum),
        .out_o(sum_r),
        .sat_o(sum_sat)
    );

    always_comb begin
        acc_d     = acc_q;
        south_d   = north_i;
        south_v_d = north_valid_i;
        sat_d     = sat_q;
        unique case (mode)
            PE_WS: begin
                if (west_valid_i) begin
                    south_d   = sum_r;
                    south_v_d = 1'b1;
                    sat_d     = sat_q | prod_sat | sum_sat;
                end
            end
            PE_OS: begin
                if (!ctrl_clear_i && ctrl_drain_i) begin
                    south_d   = acc_q;
                    south_v_d = 1'b1;
                    acc_d     = north_i;
                end else if (west_valid_i && north_valid_i) begin
                    acc_d = sum_r;
                    sat_d = sat_q | prod_sat | sum_sat;
                end
            end
        endcase
        if (ctrl_clear_i) begin
            acc_d = '0;
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            south_q   <= '0;
            south_v_q <= 1'b0;
            sat_q     <= 1'b0;
            east_q    <= '0;
            east_v_q  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            south_q   <= south_d;
            south_v_q <= south_v_d;
            sat_q     <= sat_d;
            east_q    <= west_i;
            east_v_q  <= west_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < WBANKS; i++) begin
            if (rst_i) begin
                w_q[i] <= '0;
            end else if (ctrl_load_i && ctrl_load_sel_i == SEL_W'(i)) begin
                w_q[i] <= north_i[DATA_W-1:0];
            end
        end
    end

    assign east_o        = east_q;
    assign east_valid_o  = east_v_q;
    assign south_o       = south_q;
    assign south_valid_o = south_v_q;
    assign sat_flag_o    = sat_q;

endmodule

// File: tb/tb_mac_pe_v2.sv
// Directed bench for mac_pe_v2: saturating and wrapping instances vs a model.
module tb_mac_pe_v2;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int NB = 3;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, mode, load, ps_in, drain, clear, wv, nv;
    logic [SW-1:0] lsel, wsel;
    logic signed [DW-1:0] west;
    logic signed [AW-1:0] north;

    logic [DW-1:0] east_o [2];
    logic ev_o [2];
    logic [AW-1:0] south_o [2];
    logic sv_o [2];
    logic sat_o [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mac_pe_v2 #(.DATA_W(DW), .ACC_W(AW), .WBANKS(NB), .SAT_EN(1)) u_sat (
        .clk_i(clk), .rst_i(rst), .ctrl_mode_i(mode), .ctrl_load_i(load),
        .ctrl_load_sel_i(lsel), .ctrl_wsel_i(wsel), .ctrl_ps_in_i(ps_in),
        .ctrl_drain_i(drain), .ctrl_clear_i(clear),
        .west_i(west), .west_valid_i(wv), .north_i(north), .north_valid_i(nv),
        .east_o(east_o[0]), .east_valid_o(ev_o[0]),
        .south_o(south_o[0]), .south_valid_o(sv_o[0]), .sat_flag_o(sat_o[0]));

    mac_pe_v2 #(.DATA_W(DW), .ACC_W(AW), .WBANKS(NB), .SAT_EN(0)) u_wrap (
        .clk_i(clk), .rst_i(rst), .ctrl_mode_i(mode), .ctrl_load_i(load),
        .ctrl_load_sel_i(lsel), .ctrl_wsel_i(wsel), .ctrl_ps_in_i(ps_in),
        .ctrl_drain_i(drain), .ctrl_clear_i(clear),
        .west_i(west), .west_valid_i(wv), .north_i(north), .north_valid_i(nv),
        .east_o(east_o[1]), .east_valid_o(ev_o[1]),
        .south_o(south_o[1]), .south_valid_o(sv_o[1]), .sat_flag_o(sat_o[1]));

    // Model state; index 0 saturates, index 1 wraps.
    int m_w [2][NB];
    int m_acc [2];
    int m_south [2];
    bit m_sv [2];
    bit m_flag [2];
    int m_east;
    bit m_ev;

    function automatic bit ovf(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic int fit(input int v, input bit sat);
        int t;
        if (sat) begin
            if (v > 32767) return 32767;
            if (v < -32768) return -32768;
            return v;
        end
        t = v & 32'hFFFF;
        if (t >= 32768) t -= 65536;
        return t;
    endfunction

    always @(posedge clk) begin
        int wr, s, nb, bop;
        bit sat;
        nb = int'(north);
        for (int k = 0; k < 2; k++) begin
            sat = (k == 0);
            if (rst) begin
                for (int j = 0; j < NB; j++) m_w[k][j] = 0;
                m_acc[k] = 0; m_south[k] = 0; m_sv[k] = 0; m_flag[k] = 0;
                m_east = 0; m_ev = 0;
            end else begin
                m_east = int'(west);
                m_ev = wv;
                wr = (int'(wsel) < NB) ? m_w[k][wsel] : 0;
                bop = int'($signed(north[DW-1:0]));
                if (!mode) begin
                    if (wv) begin
                        s = (ps_in ? nb : 0) + wr * int'(west);
                        m_south[k] = fit(s, sat);
                        m_sv[k] = 1;
                        if (sat && ovf(s)) m_flag[k] = 1;
                    end else begin
                        m_south[k] = nb;
                        m_sv[k] = nv;
                    end
                    if (clear) begin
                        m_acc[k] = 0; m_flag[k] = 0;
                    end
                end else if (clear) begin
                    m_acc[k] = 0; m_flag[k] = 0;
                    m_south[k] = nb; m_sv[k] = nv;
                end else if (drain) begin
                    m_south[k] = m_acc[k]; m_sv[k] = 1;
                    m_acc[k] = nb;
                end else begin
                    m_south[k] = nb; m_sv[k] = nv;
                    if (wv && nv) begin
                        s = m_acc[k] + int'(west) * bop;
                        m_acc[k] = fit(s, sat);
                        if (sat && ovf(s)) m_flag[k] = 1;
                    end
                end
                if (load && int'(lsel) < NB) m_w[k][lsel] = bop;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("east[%0d]", k), int'($signed(east_o[k])), m_east);
                check($sformatf("east_v[%0d]", k), int'(ev_o[k]), int'(m_ev));
                check($sformatf("south[%0d]", k), int'($signed(south_o[k])), m_south[k]);
                check($sformatf("south_v[%0d]", k), int'(sv_o[k]), int'(m_sv[k]));
                check($sformatf("sat[%0d]", k), int'(sat_o[k]), int'(m_flag[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int so(input int k);
        return int'($signed(south_o[k]));
    endfunction

    initial begin
        rst = 1; mode = 0; load = 0; ps_in = 0; drain = 0; clear = 0;
        wv = 0; nv = 0; lsel = 0; wsel = 0; west = 0; north = 0;
        tick();
        chk_en = 1;
        tick();
        check("rst_south", so(0), 0);
        check("rst_sat", int'(sat_o[0]), 0);
        rst = 0;

        load = 1; lsel = 0; north = 3;
        tick();
        load = 0; ps_in = 1; north = 10; west = 5; wv = 1; wsel = 0;
        tick();
        check("ws_basic_south", so(0), 25);
        check("ws_basic_valid", int'(sv_o[0]), 1);
        check("ws_basic_east", int'($signed(east_o[0])), 5);

        wv = 0; north = -50; nv = 1;
        tick();
        check("ws_pass", so(0), -50);

        load = 1; lsel = 0; north = 127; nv = 0;
        tick();
        load = 0; west = 127; wv = 1; north = 30000; ps_in = 1;
        tick();
        check("ws_sat_south", so(0), 32767);
        check("ws_sat_flag", int'(sat_o[0]), 1);
        check("ws_wrap_south", so(1), -19407);
        wv = 0; north = 0;
        tick();
        tick();
        check("sat_sticky", int'(sat_o[0]), 1);
        clear = 1;
        tick();
        clear = 0;
        check("sat_cleared", int'(sat_o[0]), 0);

        load = 1; lsel = 1; north = -2; wsel = 1; west = 4; wv = 1; ps_in = 0;
        tick();
        check("wr_old_value", so(0), 0);
        load = 0; north = 0;
        tick();
        check("wr_new_value", so(0), -8);

        load = 1; lsel = 3; north = 55; wv = 0;
        tick();
        load = 0; wsel = 3; west = 9; wv = 1; ps_in = 1; north = 100;
        tick();
        check("oor_read_zero", so(0), 100);

        wv = 0; ps_in = 0; north = 0; mode = 1; clear = 1;
        tick();
        clear = 0; wv = 1; nv = 1;
        west = 2; north = 3; tick();
        check("os_fwd_b", so(0), 3);
        west = 4; north = 5; tick();
        load = 1; lsel = 2;
        west = -1; north = 6; tick();
        load = 0; wv = 0; nv = 0; drain = 1; north = 7;
        tick();
        check("os_drain_acc", so(0), 20);
        check("os_drain_valid", int'(sv_o[0]), 1);
        north = 0;
        tick();
        check("os_drain_next", so(0), 7);

        drain = 0; wv = 1; nv = 1; west = 3; north = 3;
        tick();
        clear = 1; west = 5; north = 5;
        tick();
        clear = 0; wv = 0; nv = 0; drain = 1; north = 0;
        tick();
        check("os_clear_wins", so(0), 0);

        drain = 1; north = 32000;
        tick();
        drain = 0; wv = 1; nv = 1; west = 100; north = 100;
        tick();
        wv = 0; nv = 0; drain = 1; north = 0;
        tick();
        check("os_sat_acc", so(0), 32767);
        check("os_wrap_acc", so(1), -23536);

        drain = 0; wv = 1; nv = 1; west = 2; north = 2;
        tick();
        drain = 1; rst = 1; wv = 0; nv = 0; north = 0;
        tick();
        check("rst_drain_south", so(0), 0);
        check("rst_drain_valid", int'(sv_o[0]), 0);
        check("rst_drain_east_v", int'(ev_o[0]), 0);
        rst = 0;
        tick();
        check("rst_acc_gone", so(0), 0);

        drain = 0; mode = 0; wsel = 0; west = 1; wv = 1; ps_in = 0;
        tick();
        check("rst_weight_gone", so(0), 0);
        wv = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
